wb_slave_ram: RTL and testbench

// Parametrised Wishbone classic slave RAM: the synthesizable, configurable backing store for the Modbus-to-Wishbone bridge.

---
 rtl/wb_slave_ram.sv | 153 +++++++++++++++
 tb/tb_wb_slave_ram.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/wb_slave_ram.sv
// rtl/wb_slave_ram.sv - Wishbone classic slave RAM with wait states, window decode, read-only low region and error counter.
// Backing store for the Modbus-to-Wishbone bridge; responses are registered one edge after the RESP state.
module wb_slave_ram #(
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    ADDR_WIDTH  = 24,
    parameter int                    DEPTH       = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 24'hA00000,
    parameter int                    WAIT_STATES = 0,
    parameter int                    RO_WORDS    = 0,
    parameter int                    INIT_MUL    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  ack_o,
    output logic                  err_o,
    output logic [15:0]           errCount
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [3:0]              r_cnt;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_adr;
    logic [DATA_WIDTH-1:0]   r_dat;
    logic                    r_resp_err;
    logic                    r_ack;
    logic                    r_err;
    logic [DATA_WIDTH-1:0]   r_dat_o;
    logic [15:0]             r_err_cnt;

    logic                    w_take;
    logic                    w_we_sel;
    logic [ADDR_WIDTH-1:0]   w_adr_sel;
    logic [DATA_WIDTH-1:0]   w_dat_sel;
    logic [ADDR_WIDTH-1:0]   w_off;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_in_win;
    logic                    w_in_ro;
    logic                    w_reject;
    logic                    w_enter_resp;
    logic                    w_wr_en;
    logic [DATA_WIDTH-1:0]   w_mem [DEPTH];

    assign w_take = (r_state == ST_IDLE) && cyc_i && stb_i;

    // With no wait states the commit happens on the same edge as the request, so decode the live inputs.
    assign w_we_sel  = (r_state == ST_IDLE) ? we_i  : r_we;
    assign w_adr_sel = (r_state == ST_IDLE) ? adr_i : r_adr;
    assign w_dat_sel = (r_state == ST_IDLE) ? dat_i : r_dat;

    assign w_off    = w_adr_sel - BASE_ADDR;
    assign w_idx    = w_off[IDX_W-1:0];
    assign w_in_win = (w_adr_sel >= BASE_ADDR) && (w_off < ADDR_WIDTH'(DEPTH));

    if (RO_WORDS > 0) begin : g_ro
        assign w_in_ro = w_off < ADDR_WIDTH'(RO_WORDS);
    end else begin : g_no_ro
        assign w_in_ro = 1'b0;
    end

    assign w_reject     = !w_in_win || (w_we_sel && w_in_ro);
    assign w_enter_resp = (w_state_nxt == ST_RESP);
    assign w_wr_en      = rst && w_enter_resp && w_we_sel && !w_reject;

    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        logic [DATA_WIDTH-1:0] r_word = DATA_WIDTH'(g * INIT_MUL);
        always_ff @(posedge clk) begin
            if (w_wr_en && (w_idx == IDX_W'(g))) begin
                r_word <= w_dat_sel;
            end
        end
        assign w_mem[g] = r_word;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_take) begin
                    w_state_nxt = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!cyc_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == 4'd1) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_we       <= 1'b0;
            r_adr      <= '0;
            r_dat      <= '0;
            r_resp_err <= 1'b0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_dat_o    <= '0;
            r_err_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            if (w_take) begin
                r_we  <= we_i;
                r_adr <= adr_i;
                r_dat <= dat_i;
                r_cnt <= 4'(WAIT_STATES);
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_enter_resp) begin
                r_resp_err <= w_reject;
                r_dat_o    <= w_reject ? '0 : w_mem[w_idx];
            end
            // A master that drops cyc_i while in RESP gets no pulse at all.
            if ((r_state == ST_RESP) && cyc_i) begin
                r_ack <= !r_resp_err;
                r_err <= r_resp_err;
                if (r_resp_err && (r_err_cnt != 16'hFFFF)) begin
                    r_err_cnt <= r_err_cnt + 16'd1;
                end
            end
        end
    end

    assign dat_o    = r_dat_o;
    assign ack_o    = r_ack;
    assign err_o    = r_err;
    assign errCount = r_err_cnt;

endmodule

// File: tb/tb_wb_slave_ram.sv
// tb/tb_wb_slave_ram.sv - Randomized self-checking bench for wb_slave_ram against an array reference model.
module tb_wb_slave_ram;

    localparam int              DW    = 16;
    localparam int              AW    = 24;
    localparam int              DEPTH = 1024;
    localparam int              WS1   = 3;
    localparam int              RO1   = 4;
    localparam logic [AW-1:0]   BASE  = 24'hA00000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cyc = 1'b0;
    logic          stb = 1'b0;
    logic          we  = 1'b0;
    logic [AW-1:0] adr = '0;
    logic [DW-1:0] dat = '0;

    logic [DW-1:0] dat_o0, dat_o1;
    logic          ack0, ack1, err0, err1;
    logic [15:0]   ec0, ec1;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] m0 [DEPTH];
    logic [DW-1:0] m1 [DEPTH];
    int            exp_ec0 = 0;
    int            exp_ec1 = 0;

    always #5 clk = ~clk;

    wb_slave_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .BASE_ADDR(BASE),
                   .WAIT_STATES(0), .RO_WORDS(0), .INIT_MUL(3)) u_dut0 (
        .clk(clk), .rst(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we), .adr_i(adr), .dat_i(dat),
        .dat_o(dat_o0), .ack_o(ack0), .err_o(err0), .errCount(ec0));

    wb_slave_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .BASE_ADDR(BASE),
                   .WAIT_STATES(WS1), .RO_WORDS(RO1), .INIT_MUL(3)) u_dut1 (
        .clk(clk), .rst(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we), .adr_i(adr), .dat_i(dat),
        .dat_o(dat_o1), .ack_o(ack1), .err_o(err1), .errCount(ec1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: predicts the response of instance d and applies the write to its array.
    task automatic model(input int d, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] v,
                         output logic e, output logic [DW-1:0] rd);
        bit valid;
        int off;
        int ro;
        ro    = (d == 1) ? RO1 : 0;
        valid = (a >= BASE) && ((int'(a) - int'(BASE)) < DEPTH);
        off   = int'(a) - int'(BASE);
        e     = !valid || (w && off < ro);
        rd    = '0;
        if (!e) begin
            rd = (d == 0) ? m0[off] : m1[off];
            if (w) begin
                if (d == 0) m0[off] = v;
                else        m1[off] = v;
            end
        end
        if (e) begin
            if (d == 0 && exp_ec0 < 65535) exp_ec0++;
            if (d == 1 && exp_ec1 < 65535) exp_ec1++;
        end
    endtask

    task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] v, input bit abort1,
                        output logic [DW-1:0] o0, output logic [DW-1:0] o1);
        logic          e0, e1;
        logic [DW-1:0] r0, r1;
        model(0, w, a, v, e0, r0);
        e1 = 1'b0;
        r1 = '0;
        if (!abort1) model(1, w, a, v, e1, r1);
        o0 = '0;
        o1 = '0;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = v;
        @(posedge clk); #1;
        stb = 1'b0; we = 1'($urandom); adr = AW'($urandom); dat = DW'($urandom);
        for (int n = 1; n <= WS1 + 2; n++) begin
            @(posedge clk); #1;
            check("resp0", {ack0, err0}, (n == 1) ? {!e0, e0} : 2'b00);
            if (n == 1) begin
                o0 = dat_o0;
                check("dat0", dat_o0, r0);
            end
            check("resp1", {ack1, err1}, (n == WS1 + 1 && !abort1) ? {!e1, e1} : 2'b00);
            if (n == WS1 + 1 && !abort1) begin
                o1 = dat_o1;
                check("dat1", dat_o1, r1);
            end
            if (n == 1 && abort1) cyc = 1'b0;
        end
        cyc = 1'b0;
        check("errcnt0", ec0, exp_ec0);
        check("errcnt1", ec1, exp_ec1);
    endtask

    initial begin
        logic [DW-1:0] o0, o1, rv;
        logic          e, w;
        logic [AW-1:0] a;

        for (int i = 0; i < DEPTH; i++) begin
            m0[i] = DW'(i * 3);
            m1[i] = DW'(i * 3);
        end

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst0", {ack0, err0, dat_o0, ec0}, '0);
        check("rst1", {ack1, err1, dat_o1, ec1}, '0);
        rst = 1'b1;

        xfer(1'b0, 24'hA00005, '0, 1'b0, o0, o1);
        check("t1_rd0", o0, 16'h000F);
        check("t1_rd1", o1, 16'h000F);

        xfer(1'b1, 24'hA00010, 16'hBEEF, 1'b0, o0, o1);
        xfer(1'b0, 24'hA00010, '0, 1'b0, o0, o1);
        check("t2_rd0", o0, 16'hBEEF);
        check("t2_rd1", o1, 16'hBEEF);

        xfer(1'b0, 24'hA00400, '0, 1'b0, o0, o1);
        xfer(1'b0, 24'h9FFFFF, '0, 1'b0, o0, o1);
        check("t3_ec0", ec0, 16'd2);
        check("t3_ec1", ec1, 16'd2);

        xfer(1'b1, 24'hA00002, 16'h1234, 1'b0, o0, o1);
        xfer(1'b0, 24'hA00002, '0, 1'b0, o0, o1);
        check("t4_ro1", o1, 16'h0006);
        xfer(1'b1, 24'hA00004, 16'h1234, 1'b0, o0, o1);
        xfer(1'b0, 24'hA00004, '0, 1'b0, o0, o1);
        check("t4_rw1", o1, 16'h1234);

        xfer(1'b1, 24'hA00011, 16'h5555, 1'b1, o0, o1);
        xfer(1'b0, 24'hA00011, '0, 1'b0, o0, o1);
        check("t5_abort1", o1, 16'h0033);
        check("t5_done0", o0, 16'h5555);

        model(0, 1'b1, 24'hA00020, 16'hC0DE, e, rv);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 24'hA00020; dat = 16'hC0DE;
        @(posedge clk); #1;
        stb = 1'b0;
        @(posedge clk); #1;
        check("t6_ack0", ack0, 1'b1);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; cyc = 1'b0;
        exp_ec0 = 0;
        exp_ec1 = 0;
        check("t6_out0", {ack0, err0, dat_o0, ec0}, '0);
        check("t6_out1", {ack1, err1, dat_o1, ec1}, '0);
        xfer(1'b0, 24'hA00020, '0, 1'b0, o0, o1);
        check("t6_rd1", o1, 16'h0060);
        check("t6_rd0", o0, 16'hC0DE);

        for (int t = 0; t < 80; t++) begin
            case ($urandom_range(0, 4))
                0:       a = BASE + AW'($urandom_range(0, 15));
                1:       a = BASE + AW'($urandom_range(0, DEPTH - 1));
                2:       a = BASE + AW'(DEPTH) - AW'($urandom_range(0, 2));
                3:       a = BASE - AW'($urandom_range(1, 2));
                default: a = AW'($urandom);
            endcase
            w = 1'($urandom_range(0, 1));
            xfer(w, a, DW'($urandom), 1'b0, o0, o1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
